// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns
// (bit 0 = segment a) and the all-off pattern.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment pattern lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure table lookup, no state.
    always_comb begin
        seg = seg_lookup(nib);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-frame input snapshot,
// leading-zero suppression, PWM brightness and a frame-start pulse.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 100000,
    parameter bit ANO_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [6:0]            dout,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     ano,
    output logic                  frame_start
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned UNIT = SCAN_DIV / 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANO_IDLE = {DIGITS{ANO_ACTIVE_LOW}};

    logic [DIV_W-1:0]    div_cnt_r, div_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [4*DIGITS-1:0] snap_data_r, eff_data_s;
    logic [DIGITS-1:0]   snap_dp_r, eff_dp_s;
    logic [DIGITS-1:0]   snap_blank_r, eff_blank_s;
    logic                snap_lz_r, eff_lz_s;
    logic [3:0]          snap_bright_r, eff_bright_s;
    logic                frame_pt_s;
    logic [3:0]          nib_s;
    logic                dp_bit_s, blank_bit_s, any_nz_s, dark_s, lit_s;
    logic [31:0]         thresh_s;
    logic [6:0]          seg_s, dout_nxt_s;
    logic                dp_nxt_s;
    logic [DIGITS-1:0]   ano_nxt_s;

    seg7_decode u_decode (
        .nib (nib_s),
        .seg (seg_s)
    );

    // Slot counter and digit index advance.
    always_comb begin
        div_nxt_s = div_cnt_r + DIV_W'(1);
        idx_nxt_s = idx_r;
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // The frame's first cycle displays the values being latched, so every slot of a frame sees one snapshot.
    always_comb begin
        frame_pt_s = (div_cnt_r == '0) && (idx_r == '0);
        if (frame_pt_s) begin
            eff_data_s   = data_in;
            eff_dp_s     = dp_in;
            eff_blank_s  = blank_in;
            eff_lz_s     = lz_en;
            eff_bright_s = bright;
        end else begin
            eff_data_s   = snap_data_r;
            eff_dp_s     = snap_dp_r;
            eff_blank_s  = snap_blank_r;
            eff_lz_s     = snap_lz_r;
            eff_bright_s = snap_bright_r;
        end
    end

    // Current digit selection, leading-zero test and PWM gating.
    always_comb begin
        nib_s       = 4'h0;
        dp_bit_s    = 1'b0;
        blank_bit_s = 1'b0;
        any_nz_s    = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            nib_s       = (idx_r == IDX_W'(j)) ? eff_data_s[4*j +: 4] : nib_s;
            dp_bit_s    = (idx_r == IDX_W'(j)) ? eff_dp_s[j] : dp_bit_s;
            blank_bit_s = (idx_r == IDX_W'(j)) ? eff_blank_s[j] : blank_bit_s;
            any_nz_s    = any_nz_s | ((IDX_W'(j) >= idx_r) && (eff_data_s[4*j +: 4] != 4'h0));
        end
        dark_s   = blank_bit_s | (eff_lz_s & (idx_r != '0) & ~any_nz_s);
        thresh_s = (32'(eff_bright_s) + 32'd1) * UNIT;
        lit_s    = ~dark_s & (32'(div_cnt_r) < thresh_s);
        if (lit_s) begin
            ano_nxt_s  = DIGITS'(1'b1) << idx_r;
            dout_nxt_s = seg_s;
            dp_nxt_s   = dp_bit_s;
        end else begin
            ano_nxt_s  = '0;
            dout_nxt_s = SEG_OFF;
            dp_nxt_s   = 1'b0;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r     <= '0;
            idx_r         <= '0;
            snap_data_r   <= '0;
            snap_dp_r     <= '0;
            snap_blank_r  <= '0;
            snap_lz_r     <= 1'b0;
            snap_bright_r <= 4'h0;
            dout          <= SEG_OFF;
            dp_out        <= 1'b0;
            ano           <= ANO_IDLE;
            frame_start   <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            idx_r     <= idx_nxt_s;
            if (frame_pt_s) begin
                snap_data_r   <= data_in;
                snap_dp_r     <= dp_in;
                snap_blank_r  <= blank_in;
                snap_lz_r     <= lz_en;
                snap_bright_r <= bright;
            end
            dout        <= dout_nxt_s;
            dp_out      <= dp_nxt_s;
            ano         <= ano_nxt_s ^ ANO_IDLE;
            frame_start <= frame_pt_s;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles per digit slot (multiple of 16, at least 16).
REQ-003 Parameter ANO_ACTIVE_LOW, default 0, 1 inverts every ano bit at the output.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 data_in  in  4*DIGITS  hex nibble per digit; nibble i (bits 4i+3:4i) drives digit i.
REQ-007 dp_in  in  DIGITS  decimal point request per digit.
REQ-008 blank_in  in  DIGITS  force digit i dark.
REQ-009 lz_en  in  1  leading-zero suppression enable.
REQ-010 bright  in  4  brightness, 0 = dimmest, 15 = full duty.
REQ-011 dout  out  7  segments g..a (bit0 = a), active-high.
REQ-012 dp_out  out  1  decimal point segment, active-high.
REQ-013 ano  out  DIGITS  one-hot digit enable (active polarity per ANO_ACTIVE_LOW).
REQ-014 frame_start  out  1  one-cycle pulse per display frame.

Function
REQ-015 div_cnt SHALL count 0..SCAN_DIV-1, wrapping to 0; idx SHALL advance (mod DIGITS) on every div_cnt wrap.
REQ-016 When div_cnt==0 and idx==0, data_in, dp_in, blank_in, lz_en and bright SHALL be latched into snapshot registers; they are ignored at all other times.
REQ-017 All outputs SHALL be registered from idx, div_cnt and the snapshot, changing exactly one cycle after the state that selects them; every slot of a frame uses one snapshot.
REQ-018 Decode SHALL be hex 0..F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-019 Digit i is dark if blank_in[i], or if lz_en and nibbles i..DIGITS-1 are all 0 and i != 0; digit 0 is never zero-suppressed.
REQ-020 Dark digit: ano all inactive, dout=0, dp_out=0 for its whole slot.
REQ-021 Lit digit: ano[idx] active only while div_cnt < (bright+1)*(SCAN_DIV/16); otherwise all inactive with dout=0, dp_out=0.
REQ-022 dp_out SHALL equal dp_in[idx] (snapshot) while ano is active; a dark digit suppresses its dp.
REQ-023 frame_start SHALL be 1 for exactly the cycle in which outputs first show digit 0 of a new frame.
REQ-024 At most one ano bit SHALL be active in any cycle, under all inputs.

Reset
REQ-025 While rst=1: div_cnt=0, idx=0, snapshot=0, dout=0, dp_out=0, frame_start=0, ano all inactive (all 0, or all 1 when ANO_ACTIVE_LOW=1).
REQ-026 First rising edge with rst=0 SHALL take the snapshot (div_cnt==0, idx==0); frame_start pulses the following cycle.
REQ-027 rst asserted mid-frame SHALL abort scanning; the next frame restarts at digit 0 with a fresh snapshot.

Structure
REQ-028 Shared package seg7_pkg SHALL hold the 16-entry segment table constant and the SEG_OFF (7'h00) constant.
REQ-029 Sub-module seg7_decode (4-bit in, 7-bit out, combinational table lookup) SHALL be instantiated once.
REQ-030 Counters SHALL be sized with $clog2 of SCAN_DIV and DIGITS.

Verification (SCAN_DIV=16, DIGITS=4 unless stated)
REQ-031 data_in=16'h1234, bright=15, lz_en=0 -> ano sequence 0001,0010,0100,1000, 16 cycles each, dout 66,4F,5B,06 respectively; frame_start every 64 cycles.
REQ-032 data_in=16'h0050, lz_en=1 -> digits 3,2 dark; digit 1 = 6D, digit 0 = 3F; data_in=0 -> only digit 0 lit, 3F.
REQ-033 bright=3 -> ano active 4 of 16 cycles per slot; bright=0 -> 1 of 16.
REQ-034 data_in changed mid-frame from 16'hAAAA to 16'h5555 -> remaining slots still show 77; next frame shows 6D.
REQ-035 rst pulsed during digit 2 slot -> ano inactive, dout=0 in the following cycle; digit 0 with new snapshot appears two cycles after rst drops.
REQ-036 ANO_ACTIVE_LOW=1, DIGITS=8, dp_in=8'h80 -> ano one-cold across 8 slots, dp_out=1 only in digit 7 slot.
